// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: the FSM state encoding and the default address/data widths,
// shared by the arbiter and its bench.
package mem_port_arbiter_pkg;
    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_DM = 2'b01,
        GNT_IF = 2'b10
    } state_e;
endpackage

// File: rtl/mem_port_arbiter_wdt_counter.sv
// wdt_counter: clearable wait counter; hit_o marks the last cycle a grant may still see mem_ack.
module wdt_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic clrn,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    logic [7:0] cnt_q;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 8'd1;
    end
    // cnt_q equals the GNT cycles already spent without an ack, so TIMEOUT-1 is the final cycle
    assign hit_o = cnt_q == 8'(TIMEOUT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data memory,
// with DM priority, an anti-starvation override for fetch and a sticky timeout flag.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 15,
    parameter int STARVE  = 4
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          to_err
);
    state_e        state_q, state_d;
    logic [7:0]    starve_q;
    logic          mem_req_q, mem_we_q, if_ack_q, dm_ack_q, to_err_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
    logic          if_win, dm_win, grant, hit, done;

    assign if_win = if_req && (!dm_req || starve_q == 8'(STARVE));
    assign dm_win = dm_req && !if_win;
    assign grant  = state_q == IDLE && (if_win || dm_win);
    // mem_ack takes precedence over an expiring wait counter in the same cycle
    assign done   = state_q != IDLE && (mem_ack || hit);

    wdt_counter #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk  (clk),
        .clrn (clrn),
        .clr_i(grant),
        .en_i (state_q != IDLE && !mem_ack),
        .hit_o(hit)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = dm_win ? GNT_DM : if_win ? GNT_IF : IDLE;
        else if (done) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            to_err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            if (grant) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= dm_win && dm_we;
                mem_addr_q  <= dm_win ? dm_addr : if_addr;
                mem_wdata_q <= dm_win ? dm_wdata : '0;
                starve_q    <= if_win ? '0 : (if_req && starve_q != 8'(STARVE)) ? starve_q + 8'd1 : starve_q;
            end
            if (done) begin
                mem_req_q <= 1'b0;
                to_err_q  <= to_err_q || !mem_ack;
                if (state_q == GNT_IF) begin
                    if_ack_q   <= 1'b1;
                    if_rdata_q <= mem_ack ? mem_rdata : '0;
                end else begin
                    dm_ack_q <= 1'b1;
                    if (!mem_ack || !mem_we_q) dm_rdata_q <= mem_ack ? mem_rdata : '0;
                end
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = state_q != IDLE;
    assign to_err    = to_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized run
// against a transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;
    localparam int TIMEOUT = 15;
    localparam int STARVE  = 4;

    logic        clk = 1'b0, clrn = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic        if_ack, dm_ack, mem_req, mem_we, busy, to_err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int checks = 0, errors = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT), .STARVE(STARVE)) dut (
        .clk(clk), .clrn(clrn),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .to_err(to_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
    endtask

    typedef struct {
        logic dmr, we, ack;
        logic [31:0] addr, wdata, rdata;
        logic e_req, e_we, e_dmack, e_busy;
        logic [31:0] e_addr, e_wdata, e_dmrd;
    } vec_t;
    vec_t vecs[8];

    // reference model state: who owns the port, cycles waited, fetch losses
    int m_owner, m_wait, m_loss;
    logic m_err, m_req, m_we, m_if_ack, m_dm_ack;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd, m_v;
    bit dm_pend, if_pend;

    task automatic model_step();
        m_if_ack = 0; m_dm_ack = 0;
        if (m_owner == 0) begin
            if (if_req && (!dm_req || m_loss == STARVE)) begin
                m_owner = 2; m_loss = 0; m_addr = if_addr; m_we = 0;
            end else if (dm_req) begin
                if (if_req && m_loss < STARVE) m_loss++;
                m_owner = 1; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
            end
            if (m_owner != 0) begin m_req = 1; m_wait = 0; end
        end else begin
            m_wait++;
            if (mem_ack || m_wait == TIMEOUT) begin
                m_v = mem_ack ? mem_rdata : 32'h0;
                if (!mem_ack) m_err = 1;
                if (m_owner == 2) begin m_if_ack = 1; m_if_rd = m_v; end
                else begin m_dm_ack = 1; if (!mem_ack || !m_we) m_dm_rd = m_v; end
                m_owner = 0; m_req = 0;
            end
        end
    endtask

    initial begin
        int n, last, acks;
        bit got;
        vecs[0] = '{1,0,0, 32'h40,0,0,                   0,0,0,0, 0,0,0};
        vecs[1] = '{1,0,0, 32'h40,0,0,                   1,0,0,1, 32'h40,0,0};
        vecs[2] = '{1,0,1, 32'h40,0,32'hDEADBEEF,        1,0,0,1, 32'h40,0,0};
        vecs[3] = '{0,0,0, 0,0,0,                        0,0,1,0, 0,0,32'hDEADBEEF};
        vecs[4] = '{1,1,0, 32'h44,32'h12345678,0,        0,0,0,0, 0,0,32'hDEADBEEF};
        vecs[5] = '{1,1,1, 32'h44,32'h12345678,32'hAAAA5555, 1,1,0,1, 32'h44,32'h12345678,32'hDEADBEEF};
        vecs[6] = '{0,0,0, 0,0,0,                        0,0,1,0, 0,0,32'hDEADBEEF};
        vecs[7] = '{0,0,0, 0,0,0,                        0,0,0,0, 0,0,32'hDEADBEEF};

        // outputs while reset is held, with inputs active
        dm_req = 1; if_req = 1; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);   chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_ack", if_ack, 0);     chk("rst_dm_ack", dm_ack, 0);
        chk("rst_if_rdata", if_rdata, 0); chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_busy", busy, 0);         chk("rst_to_err", to_err, 0);
        do_reset();

        // single load then store
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].e_req);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_dm_ack", i), dm_ack, vecs[i].e_dmack);
            chk($sformatf("vec%0d_dm_rdata", i), dm_rdata, vecs[i].e_dmrd);
            if (vecs[i].e_req) begin
                chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
                chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].e_we);
                if (vecs[i].e_we) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            if_req = 0; dm_req = vecs[i].dmr; dm_we = vecs[i].we; mem_ack = vecs[i].ack;
            dm_addr = vecs[i].addr; dm_wdata = vecs[i].wdata; mem_rdata = vecs[i].rdata;
        end

        // contention with combinational ack: DM x4 then IF, one ack every 2 cycles
        @(negedge clk);
        if_req = 1; dm_req = 1; dm_we = 0; if_addr = 32'h100; dm_addr = 32'h200;
        acks = 0; last = -1;
        for (int c = 0; c < 40 && acks < 10; c++) begin
            @(negedge clk);
            mem_ack = mem_req; mem_rdata = 32'hC0DE0000 | c;
            if (if_ack || dm_ack) begin
                chk($sformatf("cont_owner%0d", acks), {31'b0, if_ack}, (acks % 5 == 4) ? 1 : 0);
                chk("cont_one_ack", {31'b0, if_ack & dm_ack}, 0);
                if (last >= 0) chk("cont_spacing", c - last, 2);
                last = c; acks++;
                if (acks == 10) begin if_req = 0; dm_req = 0; end
            end
        end
        chk("cont_count", acks, 10);
        chk("cont_if_rdata_nonzero", {31'b0, if_rdata != 0}, 1);
        mem_ack = 0;

        // fetch timeout with mem_ack stuck low
        @(negedge clk);
        if_req = 1; if_addr = 32'h300;
        n = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (mem_req) n++;
            if (if_ack) begin
                got = 1;
                chk("to_if_rdata", if_rdata, 0);
                chk("to_err_set", to_err, 1);
                chk("to_mem_req_low", mem_req, 0);
                if_req = 0;
            end
        end
        chk("to_ack_seen", got, 1);
        chk("to_gnt_cycles", n, TIMEOUT);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", to_err, 1);
        chk("to_idle", busy, 0);

        // ack in the last allowed GNT cycle wins over the timeout
        do_reset();
        dm_req = 1; dm_we = 0; dm_addr = 32'h80;
        n = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            mem_ack = 0;
            if (mem_req) begin
                n++;
                if (n == TIMEOUT) begin mem_ack = 1; mem_rdata = 32'h0BADF00D; end
            end
            if (dm_ack) begin
                got = 1;
                chk("late_dm_rdata", dm_rdata, 32'h0BADF00D);
                chk("late_to_err", to_err, 0);
                dm_req = 0;
            end
        end
        chk("late_ack_seen", got, 1);
        chk("late_gnt_cycles", n, TIMEOUT);
        mem_ack = 0;

        // reset in the middle of a DM grant aborts it silently
        @(negedge clk);
        dm_req = 1; dm_addr = 32'h90;
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        clrn = 0;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_dm_ack", dm_ack, 0);
        @(negedge clk);
        dm_req = 0; clrn = 1;
        n = 0;
        repeat (5) begin @(negedge clk); if (dm_ack) n++; end
        chk("abort_no_ack", n, 0);

        // randomized traffic against the reference model
        do_reset();
        m_owner = 0; m_wait = 0; m_loss = 0; m_err = 0; m_req = 0; m_we = 0;
        m_if_ack = 0; m_dm_ack = 0; m_addr = 0; m_wdata = 0; m_if_rd = 0; m_dm_rd = 0;
        dm_pend = 0; if_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_mem_req", mem_req, m_req);
            chk("rnd_busy", busy, m_owner != 0);
            chk("rnd_if_ack", if_ack, m_if_ack);
            chk("rnd_dm_ack", dm_ack, m_dm_ack);
            chk("rnd_if_rdata", if_rdata, m_if_rd);
            chk("rnd_dm_rdata", dm_rdata, m_dm_rd);
            chk("rnd_to_err", to_err, m_err);
            if (m_req) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_we", mem_we, m_we);
                if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            if (m_dm_ack) dm_pend = 0;
            if (m_if_ack) if_pend = 0;
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend = 1; dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
            end
            if (!if_pend && $urandom_range(0, 1) == 0) begin
                if_pend = 1; if_addr = $urandom;
            end
            dm_req = dm_pend; if_req = if_pend;
            mem_ack = $urandom_range(0, 3) == 0;
            mem_rdata = $urandom;
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
